multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer FSM for the RV32I core datapath; supersedes the purely combinational opcode decode.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the write enables, mux selects and a single shared instruction/data memory port (req/ready handshake).
- Adds illegal-opcode and memory-timeout traps plus a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req may wait for mem_ready before trapping; legal range 2..255.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- run_en  in  1  allow starting a new instruction
- opcode  in  7  IR[6:0]; valid from DECODE onward
- br_taken  in  1  branch comparison result from ALU, sampled in EXEC
- mem_ready  in  1  memory accepts/completes the current request
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = read
- addr_sel  out  1  memory address mux: 0 = PC, 1 = ALU result
- ir_write  out  1  latch fetched word into IR
- pc_write  out  1  update PC
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target
- reg_write  out  1  register file write enable
- alu_b_sel  out  1  ALU B mux: 1 = rs2, 0 = immediate
- wb_sel  out  1  writeback mux: 0 = ALU, 1 = load data
- retire  out  1  one-cycle pulse on instruction completion
- instret  out  CNT_W  retired-instruction count
- trap  out  1  sticky fault flag
- trap_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 data timeout
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; instret = 0; trap = 0; trap_cause = 00.
  - All other outputs 0.
- Output style: Moore decode of the registered state and opcode. The exceptions are ir_write, pc_write and retire, which also qualify on mem_ready or br_taken as listed below.
- IDLE:
  - run_en=1 → FETCH next cycle; otherwise stay in IDLE.
- FETCH:
  - Drive mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0 in the same cycle, then → DECODE.
- DECODE:
  - Opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store) and 1100011 (branch) → EXEC.
  - Any other opcode → TRAP with cause 01.
- EXEC:
  - alu_b_sel = 1 for R and branch, 0 otherwise.
  - R and I-ALU → WB.
  - Load and store → MEM.
  - Branch: pc_write = br_taken, pc_src = 1, retire = 1, then → FETCH or IDLE.
- MEM:
  - Drive mem_req=1, addr_sel=1; mem_we = 1 for store, 0 for load.
  - alu_b_sel is held at 0 so the address stays stable.
  - On mem_ready: a load → WB; a store raises retire and → FETCH or IDLE.
- WB:
  - reg_write = 1; wb_sel = 1 for load, 0 for R and I-ALU; retire = 1.
  - Then → FETCH or IDLE.
- Return target after any retire: FETCH if run_en=1, else IDLE.
  - run_en=0 never aborts an instruction in progress.
- Handshake rules:
  - mem_req and all address/we selects stay stable from assertion until the mem_ready cycle.
  - Exactly one transfer completes per ready.
- Timeout:
  - A wait counter clears on entering FETCH or MEM and increments each cycle that mem_req=1 and mem_ready=0.
  - When the counter reaches MEM_TIMEOUT-1 and mem_ready is still 0 → TRAP. Cause is 10 if the state was FETCH, 11 if MEM.
  - If mem_ready is asserted in the same cycle as the limit, ready wins and no trap occurs.
- TRAP:
  - All enables and mem_req are 0; trap = 1; trap_cause is held.
  - TRAP is exited only by reset.
- instret:
  - Increments by 1 in the cycle after retire; wraps from 2^CNT_W-1 to 0.
- Zero-wait latencies, including the FETCH cycle:
  - R/I-ALU: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - Each memory wait state adds 1 cycle.
- Reset mid-instruction: immediate return to IDLE. No retire is issued and partial state is discarded.

Decomposition:
- Package rv_ctrl_pkg:
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
  - state enum IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP (3-bit)
  - trap-cause constants
  - mux-select constants (ALU_B_REG=1, ALU_B_IMM=0, WB_ALU=0, WB_MEM=1)
- Sub-module mem_wait_timer: clear, count-enable and MEM_TIMEOUT compare, producing a single expired output.

Test Plan:
- Reset, then hold run_en=0 → state stays IDLE, every output 0, instret=0; release rst_n asynchronously mid-cycle without glitches.
- run_en=1, opcode=0110011, mem_ready tied 1 → states FETCH, DECODE, EXEC, WB; reg_write=1 and alu_b_sel=1 in WB; retire on cycle 4; instret=1.
- Load (0000011) with 2 wait states on fetch and 1 on data → 8 cycles total; wb_sel=1 in WB; mem_req stable through the waits; addr_sel=1 in MEM.
- Store (0100011), then branch (1100011) with br_taken=1 → store: mem_we=1 in MEM, reg_write never asserted. Branch: pc_write=1 and pc_src=1 in EXEC; repeat with br_taken=0 → pc_write=0 in EXEC, retire still asserted.
- Opcode 1111111 → TRAP with cause 01, trap=1, no reg_write; remains in TRAP until rst_n.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH → TRAP with cause 10 after 4 wait cycles. Repeat with ready arriving exactly on the limit cycle → no trap. Repeat the timeout in load MEM → cause 11.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, states, trap causes and mux selects for the multicycle controller
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
    localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

    localparam logic ALU_B_REG = 1'b1;
    localparam logic ALU_B_IMM = 1'b0;
    localparam logic WB_ALU    = 1'b0;
    localparam logic WB_MEM    = 1'b1;

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-state counter that flags when a memory request has waited too long
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The limit cycle itself is the last one on which ready may still arrive.
    assign expired = (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer with shared memory port, traps and instret
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             alu_b_sel,
    output logic             wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o
);

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             expired;
    logic             is_r, is_load, is_store, is_br;
    state_t           after_retire;

    assign is_r         = (opcode == OP_R);
    assign is_load      = (opcode == OP_LOAD);
    assign is_store     = (opcode == OP_STORE);
    assign is_br        = (opcode == OP_BRANCH);
    assign after_retire = run_en ? FETCH : IDLE;

    // Any cycle without a stalled request restarts the wait count.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!mem_req || mem_ready),
        .count_en (mem_req && !mem_ready),
        .expired  (expired)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        alu_b_sel = ALU_B_IMM;
        wb_sel    = WB_ALU;
        retire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (run_en) state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_FETCH_TO;
                end
            end
            DECODE: begin
                if (op_legal(opcode)) begin
                    state_d = EXEC;
                end else begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            EXEC: begin
                alu_b_sel = (is_r || is_br) ? ALU_B_REG : ALU_B_IMM;
                if (is_br) begin
                    pc_write = br_taken;
                    pc_src   = 1'b1;
                    retire   = 1'b1;
                    state_d  = after_retire;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = after_retire;
                    end else begin
                        state_d = WB;
                    end
                end else if (expired) begin
                    state_d = TRAP;
                    cause_d = CAUSE_DATA_TO;
                end
            end
            WB: begin
                reg_write = 1'b1;
                wb_sel    = is_load ? WB_MEM : WB_ALU;
                alu_b_sel = is_r ? ALU_B_REG : ALU_B_IMM;
                retire    = 1'b1;
                state_d   = after_retire;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign trap       = (state_q == TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against a phase-table model
module tb_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, run_en, br_taken, mem_ready;
    logic [6:0]    opcode;
    logic          mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
    logic          reg_write, alu_b_sel, wb_sel, retire, trap;
    logic [CW-1:0] instret;
    logic [1:0]    trap_cause;
    logic [2:0]    state_o;
    logic [10:0]   obs;

    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;
    logic [1:0] exp_cause = 2'b00;
    bit   in_idle = 1'b1;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .opcode(opcode),
        .br_taken(br_taken), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                  reg_write, alu_b_sel, wb_sel, retire, trap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Expected control outputs for one cycle of a given phase, straight from the instruction-class rules.
    function automatic logic [10:0] exp_vec(input state_t ph, input logic [6:0] op,
                                            input bit rdy, input bit tk);
        bit req = 0, we = 0, asel = 0, irw = 0, pcw = 0, psrc = 0;
        bit rw = 0, bsel = 0, wsel = 0, ret = 0, tr = 0;
        case (ph)
            FETCH:  begin req = 1; irw = rdy; pcw = rdy; end
            EXEC:   begin
                bsel = (op == OP_R) || (op == OP_BRANCH);
                if (op == OP_BRANCH) begin pcw = tk; psrc = 1; ret = 1; end
            end
            MEM:    begin
                req = 1; asel = 1; we = (op == OP_STORE);
                ret = (op == OP_STORE) && rdy;
            end
            WB:     begin rw = 1; wsel = (op == OP_LOAD); bsel = (op == OP_R); ret = 1; end
            TRAP:   tr = 1;
            default: ;
        endcase
        return {req, we, asel, irw, pcw, psrc, rw, bsel, wsel, ret, tr};
    endfunction

    task automatic step(input state_t ph, input bit rdy, input bit tk, input bit ren);
        logic [10:0] e;
        mem_ready = rdy;
        br_taken  = tk;
        run_en    = ren;
        e = exp_vec(ph, opcode, rdy, tk);
        @(negedge clk);
        check({"state_", ph.name()}, 32'(state_o), 32'(ph));
        check({"outs_", ph.name()}, 32'(obs), 32'(e));
        check("instret", 32'(instret), 32'(exp_cnt));
        check("cause", 32'(trap_cause), (ph == TRAP) ? 32'(exp_cause) : 32'd0);
        if (e[1]) exp_cnt = (exp_cnt + 1) % (1 << CW);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        run_en = 0; mem_ready = 0; br_taken = 0;
        #2 rst_n = 0;
        #1;
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_outs", 32'(obs), 32'd0);
        check("rst_instret", 32'(instret), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        exp_cnt = 0; exp_cause = 2'b00; in_idle = 1;
    endtask

    task automatic run_instr(input logic [6:0] op, input int wf, input int wd,
                             input bit tk, input bit cont);
        bit br = (op == OP_BRANCH);
        bit st = (op == OP_STORE);
        bit ld = (op == OP_LOAD);
        opcode = op;
        if (in_idle) step(IDLE, rb(), rb(), 1);
        for (int i = 0; i < wf; i++) step(FETCH, 0, rb(), rb());
        step(FETCH, 1, rb(), rb());
        step(DECODE, rb(), rb(), rb());
        step(EXEC, rb(), tk, br ? cont : rb());
        if (ld || st) begin
            for (int i = 0; i < wd; i++) step(MEM, 0, rb(), rb());
            step(MEM, 1, rb(), st ? cont : rb());
        end
        if (!br && !st) step(WB, rb(), rb(), cont);
        in_idle = !cont;
    endtask

    task automatic enter_fetch(input logic [6:0] op);
        opcode = op;
        if (in_idle) step(IDLE, 0, 0, 1);
    endtask

    logic [6:0] ops [5];

    initial begin
        ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH};
        rst_n = 0; run_en = 0; br_taken = 0; mem_ready = 0; opcode = OP_R;
        @(posedge clk);
        #1;
        do_reset();
        repeat (3) step(IDLE, rb(), rb(), 0);

        run_instr(OP_R, 0, 0, 0, 0);
        check("instret_after_r", 32'(instret), 32'd1);
        run_instr(OP_LOAD, 2, 1, 0, 1);
        run_instr(OP_STORE, 0, 0, 0, 1);
        run_instr(OP_BRANCH, 0, 0, 1, 1);
        run_instr(OP_BRANCH, 0, 0, 0, 0);
        run_instr(OP_LOAD, TO - 1, TO - 1, 0, 1);
        run_instr(OP_STORE, TO - 1, TO - 1, 0, 0);

        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), rb(), rb());

        enter_fetch(7'b1111111);
        step(FETCH, 1, 0, 1);
        step(DECODE, 0, 0, 1);
        exp_cause = CAUSE_ILLEGAL;
        repeat (4) step(TRAP, rb(), rb(), 1);
        do_reset();

        enter_fetch(OP_R);
        for (int i = 0; i < TO; i++) step(FETCH, 0, 0, 1);
        exp_cause = CAUSE_FETCH_TO;
        repeat (3) step(TRAP, rb(), rb(), 1);
        do_reset();

        enter_fetch(OP_LOAD);
        step(FETCH, 1, 0, 1);
        step(DECODE, 0, 0, 1);
        step(EXEC, 0, 0, 1);
        for (int i = 0; i < TO; i++) step(MEM, 0, 0, 1);
        exp_cause = CAUSE_DATA_TO;
        repeat (3) step(TRAP, rb(), rb(), 1);
        do_reset();

        run_instr(OP_IMM, 1, 0, 0, 1);
        opcode = OP_LOAD;
        step(FETCH, 1, 0, 1);
        step(DECODE, 0, 0, 1);
        step(EXEC, 0, 0, 1);
        do_reset();
        step(IDLE, 1, 1, 0);
        run_instr(OP_R, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
